// File: rtl/tdc_sum_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tdc_sum_sequencer
// Brief  : Frame controller that gathers per-channel TDC hits, launches the
//          summing pipeline once per frame and averages 2^LOG2_NAVG sums.
// Rev    : 1.0  initial release
// ============================================================================
module tdc_sum_sequencer #(
    parameter int LOG2_NAVG   = 2,
    parameter int COLLECT_TMO = 1000,
    parameter int SUM_TMO     = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         arm,
    input  logic [15:0]  ch_mask,
    input  logic [15:0]  ch_dval,
    input  logic [159:0] ch_int,
    input  logic [111:0] ch_frac,
    output logic         mlt_start,
    output logic [159:0] mlt_int,
    output logic [111:0] mlt_frac,
    input  logic [36:0]  mlt_sum,
    input  logic         mlt_dval,
    output logic [36:0]  res_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy,
    output logic         err_tmo,
    output logic         err_ovr,
    output logic [7:0]   drop_cnt,
    input  logic         err_clr
);

    localparam int ACC_W   = 37 + LOG2_NAVG;
    localparam int TMO_MAX = (COLLECT_TMO > SUM_TMO) ? COLLECT_TMO : SUM_TMO;
    localparam int TMO_W   = $clog2(TMO_MAX);
    localparam int FRM_W   = LOG2_NAVG + 1;

    localparam logic [TMO_W-1:0] C_COLLECT_LAST = TMO_W'(COLLECT_TMO - 1);
    localparam logic [TMO_W-1:0] C_SUM_LAST     = TMO_W'(SUM_TMO - 1);
    localparam logic [FRM_W-1:0] C_NAVG         = FRM_W'(1) << LOG2_NAVG;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_LAUNCH   = 3'd2,
        S_WAIT_SUM = 3'd3,
        S_ACCUM    = 3'd4,
        S_OUTPUT   = 3'd5
    } state_t;

    state_t             state_q;
    logic [15:0]        mask_q;
    logic [15:0]        hit_q;
    logic [15:0]        hit_new;
    logic [15:0]        hit_d;
    logic [159:0]       int_q;
    logic [159:0]       int_d;
    logic [111:0]       frac_q;
    logic [111:0]       frac_d;
    logic [TMO_W-1:0]   tmo_q;
    logic [36:0]        sum_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [FRM_W-1:0]   frame_q;
    logic [FRM_W-1:0]   frame_d;
    logic [36:0]        res_data_q;
    logic               res_valid_q;
    logic               mlt_start_q;
    logic               err_tmo_q;
    logic               err_ovr_q;
    logic [7:0]         drop_q;
    logic [7:0]         drop_d;
    logic               tmo_evt;
    logic               ovr_evt;

    always_comb begin
        hit_new = ch_dval & mask_q & ~hit_q;
        hit_d   = hit_q | hit_new;
        int_d   = int_q;
        frac_d  = frac_q;
        // Only the first strobe of a channel is latched; later ones see hit_q set.
        for (int i = 0; i < 16; i++) begin
            if (hit_new[i]) begin
                int_d[10*i +: 10] = ch_int[10*i +: 10];
                frac_d[7*i +: 7]  = ch_frac[7*i +: 7];
            end
        end
        acc_d   = acc_q + ACC_W'(sum_q);
        frame_d = frame_q + FRM_W'(1);
        drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        tmo_evt = ((state_q == S_COLLECT) && (hit_d != mask_q) && (tmo_q == C_COLLECT_LAST)) ||
                  ((state_q == S_WAIT_SUM) && !mlt_dval && (tmo_q == C_SUM_LAST));
        ovr_evt = arm && (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            hit_q       <= '0;
            int_q       <= '0;
            frac_q      <= '0;
            tmo_q       <= '0;
            sum_q       <= '0;
            acc_q       <= '0;
            frame_q     <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            mlt_start_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            if (err_clr) begin
                err_tmo_q <= 1'b0;
                err_ovr_q <= 1'b0;
                drop_q    <= '0;
            end else begin
                if (tmo_evt) begin
                    err_tmo_q <= 1'b1;
                    drop_q    <= drop_d;
                end
                if (ovr_evt) begin
                    err_ovr_q <= 1'b1;
                end
            end

            mlt_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arm && (ch_mask != 16'h0000)) begin
                        mask_q  <= ch_mask;
                        hit_q   <= '0;
                        int_q   <= '0;
                        frac_q  <= '0;
                        tmo_q   <= '0;
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    hit_q  <= hit_d;
                    int_q  <= int_d;
                    frac_q <= frac_d;
                    if (hit_d == mask_q) begin
                        mlt_start_q <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end else if (tmo_q == C_COLLECT_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_LAUNCH: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT_SUM;
                end
                S_WAIT_SUM: begin
                    if (mlt_dval) begin
                        sum_q   <= mlt_sum;
                        state_q <= S_ACCUM;
                    end else if (tmo_q == C_SUM_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_ACCUM: begin
                    acc_q   <= acc_d;
                    frame_q <= frame_d;
                    if (frame_d == C_NAVG) begin
                        res_data_q  <= acc_d[ACC_W-1:LOG2_NAVG];
                        res_valid_q <= 1'b1;
                        state_q     <= S_OUTPUT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        acc_q       <= '0;
                        frame_q     <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mlt_start = mlt_start_q;
    assign mlt_int   = int_q;
    assign mlt_frac  = frac_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign err_tmo   = err_tmo_q;
    assign err_ovr   = err_ovr_q;
    assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_tdc_sum_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_tdc_sum_sequencer
// Brief  : Randomised frame stimulus with queue-based scoreboard for
//          tdc_sum_sequencer; includes a 6-cycle summing pipeline model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tdc_sum_sequencer;

    localparam int L        = 2;
    localparam int NAVG     = 4;
    localparam int CTMO     = 100;
    localparam int STMO     = 15;
    localparam int PIPE_LAT = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         arm = 1'b0;
    logic [15:0]  ch_mask = '0;
    logic [15:0]  ch_dval = '0;
    logic [159:0] ch_int = '0;
    logic [111:0] ch_frac = '0;
    logic         mlt_start;
    logic [159:0] mlt_int;
    logic [111:0] mlt_frac;
    logic [36:0]  mlt_sum = '0;
    logic         mlt_dval = 1'b0;
    logic [36:0]  res_data;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         busy;
    logic         err_tmo;
    logic         err_ovr;
    logic [7:0]   drop_cnt;
    logic         err_clr = 1'b0;

    always #5 clk = ~clk;

    tdc_sum_sequencer #(
        .LOG2_NAVG   (L),
        .COLLECT_TMO (CTMO),
        .SUM_TMO     (STMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .ch_mask   (ch_mask),
        .ch_dval   (ch_dval),
        .ch_int    (ch_int),
        .ch_frac   (ch_frac),
        .mlt_start (mlt_start),
        .mlt_int   (mlt_int),
        .mlt_frac  (mlt_frac),
        .mlt_sum   (mlt_sum),
        .mlt_dval  (mlt_dval),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .err_tmo   (err_tmo),
        .err_ovr   (err_ovr),
        .drop_cnt  (drop_cnt),
        .err_clr   (err_clr)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard queues and the averaging reference model
    logic [159:0] q_int[$];
    logic [111:0] q_frac[$];
    logic [36:0]  q_res[$];
    longint       m_acc = 0;
    int           m_cnt = 0;

    // Summing pipeline: sum of int*50+frac, delivered PIPE_LAT cycles after start
    int          pcnt = 0;
    logic [36:0] psum = '0;
    always @(posedge clk) begin
        #1;
        mlt_dval = 1'b0;
        if (pcnt > 0) begin
            pcnt--;
            if (pcnt == 0) begin
                mlt_dval = 1'b1;
                mlt_sum  = psum;
            end
        end
        if (mlt_start) begin
            pcnt = PIPE_LAT;
            psum = '0;
            for (int i = 0; i < 16; i++)
                psum = psum + 37'(mlt_int[10*i +: 10]) * 37'd50 + 37'(mlt_frac[7*i +: 7]);
        end
    end

    int ready_sel = 0;
    always @(posedge clk) begin
        #1;
        case (ready_sel)
            0:       res_ready = ($urandom_range(0, 1) == 1);
            1:       res_ready = 1'b0;
            default: res_ready = 1'b1;
        endcase
    end

    // Monitor
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    logic [36:0] held = '0;
    int          last_hit_cyc = -10;
    int          last_dval_cyc = -10;
    int          starts = 0;
    always @(negedge clk) begin
        if (mlt_dval) last_dval_cyc = cyc;
        if (mlt_start) begin
            starts++;
            chk("start_latency", 160'(cyc), 160'(last_hit_cyc + 1));
            chk("start_expected", 160'(q_int.size() > 0), 160'(1));
            if (q_int.size() > 0) begin
                chk("mlt_int", mlt_int, q_int.pop_front());
                chk("mlt_frac", 160'(mlt_frac), 160'(q_frac.pop_front()));
            end
        end
        if (res_valid && !prev_valid) begin
            chk("dval_to_valid", 160'(cyc - last_dval_cyc), 160'(2));
            held = res_data;
        end
        if (res_valid && prev_valid) chk("res_stable", 160'(res_data), 160'(held));
        if (!res_valid && prev_valid) chk("valid_drop_after_hs", 160'(prev_ready), 160'(1));
        if (res_valid && res_ready) begin
            chk("result_expected", 160'(q_res.size() > 0), 160'(1));
            if (q_res.size() > 0) chk("res_data", 160'(res_data), 160'(q_res.pop_front()));
        end
        prev_valid = res_valid;
        prev_ready = res_ready;
    end

    // Stimulus
    logic [9:0]  vint[16];
    logic [6:0]  vfrac[16];
    logic [15:0] pending = '0;
    logic [15:0] cur_mask = '0;
    logic [15:0] starve_m = '0;
    int          vmode = 0;
    int          arm_cyc = 0;
    int          starts0 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_vals(input int mode);
        vmode = mode;
        for (int i = 0; i < 16; i++) begin
            case (mode)
                1: begin vint[i] = 10'd1; vfrac[i] = 7'd0; end
                2: begin
                    vint[i]  = (i == 0) ? 10'd3 : (i == 2) ? 10'd2 : 10'd0;
                    vfrac[i] = (i == 0) ? 7'd10 : (i == 2) ? 7'd7 : 7'd0;
                end
                default: begin
                    vint[i]  = 10'($urandom_range(0, 1023));
                    vfrac[i] = 7'($urandom_range(0, 127));
                end
            endcase
        end
    endtask

    function automatic longint frame_sum(input logic [15:0] mask);
        longint s = 0;
        for (int i = 0; i < 16; i++)
            if (mask[i]) s += longint'(vint[i]) * 50 + longint'(vfrac[i]);
        return s;
    endfunction

    task automatic start_frame(input logic [15:0] mask, input logic [15:0] starve, input bit ok);
        logic [159:0] ei = '0;
        logic [111:0] ef = '0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
                ei[10*i +: 10] = vint[i];
                ef[7*i +: 7]   = vfrac[i];
            end
        end
        if (ok) begin
            q_int.push_back(ei);
            q_frac.push_back(ef);
        end
        pending  = mask & ~starve;
        cur_mask = mask;
        starve_m = starve;
        starts0  = starts;
        arm      = 1'b1;
        ch_mask  = mask;
        arm_cyc  = cyc;
        tick();
        arm     = 1'b0;
        ch_mask = 16'($urandom);
    endtask

    task automatic hit_cycle(input bit all);
        logic [15:0] dv = '0;
        bit had = (pending != 0);
        for (int i = 0; i < 16; i++) begin
            if (pending[i] && (all || $urandom_range(0, 1) == 1)) begin
                dv[i]             = 1'b1;
                ch_int[10*i +: 10] = vint[i];
                ch_frac[7*i +: 7]  = vfrac[i];
                pending[i]        = 1'b0;
            end else if (!cur_mask[i] || (!pending[i] && !starve_m[i])) begin
                // Stray strobes: unmasked or already-captured channels
                if ((vmode == 2 && i == 1) || $urandom_range(0, 2) == 0) begin
                    dv[i]             = 1'b1;
                    ch_int[10*i +: 10] = (vmode == 2) ? 10'd1023 : 10'($urandom_range(0, 1023));
                    ch_frac[7*i +: 7]  = 7'($urandom_range(0, 127));
                end
            end
        end
        ch_dval = dv;
        if (had && pending == 0) last_hit_cyc = cyc;
        tick();
        ch_dval = '0;
    endtask

    task automatic finish_hits(input bit all);
        int n = 0;
        while (pending != 0 && n < 60) begin
            hit_cycle(all);
            n++;
        end
    endtask

    task automatic model_accept(input logic [15:0] mask);
        m_acc += frame_sum(mask);
        m_cnt++;
        if (m_cnt == NAVG) begin
            q_res.push_back(37'(m_acc >> L));
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, 160'(busy), 160'(0));
    endtask

    task automatic good_frame(input logic [15:0] mask, input int mode);
        gen_vals(mode);
        start_frame(mask, 16'h0000, 1'b1);
        finish_hits(1'b0);
        model_accept(mask);
        wait_idle(300, "frame");
        chk("one_start", 160'(starts - starts0), 160'(1));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_flags", 160'({busy, res_valid, mlt_start, err_tmo, err_ovr}), 160'(0));
        chk("rst_drop_cnt", 160'(drop_cnt), 160'(0));
        chk("rst_res_data", 160'(res_data), 160'(0));
        chk("rst_operands", mlt_int | 160'(mlt_frac), 160'(0));
        pending = '0;
        ch_dval = '0;
        tick();
        tick();
        rst   = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        q_int.delete();
        q_frac.delete();
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("init_flags", 160'({busy, res_valid, mlt_start, err_tmo, err_ovr}), 160'(0));
        chk("init_drop_cnt", 160'(drop_cnt), 160'(0));
        chk("init_res_data", 160'(res_data), 160'(0));
        rst = 1'b1;
        tick();

        for (int f = 0; f < 4; f++) good_frame(16'hFFFF, 1);
        for (int f = 0; f < 4; f++) good_frame(16'h0005, 2);
        for (int f = 0; f < 8; f++) good_frame(16'($urandom_range(1, 65535)), 0);

        // Channel 15 never hits: the frame must be dropped after the collect timeout
        gen_vals(0);
        start_frame(16'hFFFF, 16'h8000, 1'b0);
        finish_hits(1'b1);
        wait_idle(CTMO + 20, "tmo");
        chk("tmo_duration", 160'(cyc - arm_cyc), 160'(CTMO + 1));
        chk("tmo_err_tmo", 160'(err_tmo), 160'(1));
        chk("tmo_drop_cnt", 160'(drop_cnt), 160'(1));
        chk("tmo_no_start", 160'(starts - starts0), 160'(0));
        for (int f = 0; f < 4; f++) good_frame(16'($urandom_range(1, 65535)), 0);

        // Arm while waiting for the pipeline sum
        gen_vals(0);
        start_frame(16'hFFFF, 16'h0000, 1'b1);
        finish_hits(1'b0);
        tick();
        chk("in_wait_sum_busy", 160'(busy), 160'(1));
        arm     = 1'b1;
        ch_mask = 16'hFFFF;
        tick();
        arm = 1'b0;
        model_accept(16'hFFFF);
        wait_idle(300, "ovr_frame");
        chk("ovr_one_start", 160'(starts - starts0), 160'(1));
        chk("ovr_set", 160'(err_ovr), 160'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_flags", 160'({err_tmo, err_ovr}), 160'(0));
        chk("clr_drop_cnt", 160'(drop_cnt), 160'(0));

        // Back-pressure on the fourth frame of the group
        for (int f = 0; f < 2; f++) good_frame(16'($urandom_range(1, 65535)), 0);
        ready_sel = 1;
        gen_vals(0);
        start_frame(16'hFFFF, 16'h0000, 1'b1);
        finish_hits(1'b0);
        model_accept(16'hFFFF);
        for (int n = 0; n < 30 && !res_valid; n++) tick();
        chk("bp_valid", 160'(res_valid), 160'(1));
        for (int n = 0; n < 50; n++) begin
            arm     = (n % 10 == 3);
            ch_mask = 16'hFFFF;
            tick();
        end
        arm = 1'b0;
        chk("bp_still_valid", 160'(res_valid), 160'(1));
        chk("bp_arm_ovr", 160'(err_ovr), 160'(1));
        chk("bp_one_start", 160'(starts - starts0), 160'(1));
        ready_sel = 2;
        wait_idle(10, "bp_release");
        chk("bp_valid_low", 160'(res_valid), 160'(0));
        ready_sel = 0;

        // Reset during COLLECT
        gen_vals(0);
        start_frame(16'hFFFF, 16'h8000, 1'b0);
        hit_cycle(1'b0);
        hit_cycle(1'b0);
        do_reset();

        // Reset during WAIT_SUM, late pipeline result must be ignored
        gen_vals(0);
        start_frame(16'hFFFF, 16'h0000, 1'b1);
        finish_hits(1'b0);
        tick();
        tick();
        do_reset();
        repeat (10) tick();
        chk("late_dval_busy", 160'(busy), 160'(0));
        chk("late_dval_valid", 160'(res_valid), 160'(0));
        for (int f = 0; f < 4; f++) good_frame(16'($urandom_range(1, 65535)), 0);

        repeat (5) tick();
        chk("results_drained", 160'(q_res.size()), 160'(0));
        chk("starts_drained", 160'(q_int.size()), 160'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
